// File: rtl/antfarm_pkg.sv
// Shared antfarm constants and types: cell-code width, grid dimensions and the
// scanner state encoding used by the grid RAM, scanner and display decoder.
package antfarm_pkg;

   localparam int CELL_W    = 5;
   localparam int GRID_COLS = 16;
   localparam int GRID_ROWS = 8;

   typedef logic [CELL_W-1:0] cell_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_COMMIT
   } scan_state_t;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/grid_view_scanner_refresh_timer.sv
// Free-running modulo-DIV counter; tick is high on the terminal count, once
// every DIV clocks, with the first tick DIV-1 clocks after reset release.
module refresh_timer
   import antfarm_pkg::*;
#(
   parameter int  DIV = 50000,
   localparam int CW  = idx_width(DIV)
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [CW-1:0] count_reg;

   assign tick = (count_reg == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (tick) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/grid_view_scanner.sv
// Reads a window of DIGITS cells from one grid row into shadow registers and
// commits them to the display outputs atomically, once per refresh or request.
module grid_view_scanner
   import antfarm_pkg::*;
#(
   parameter int  COLS        = GRID_COLS,
   parameter int  ROWS        = GRID_ROWS,
   parameter int  DIGITS      = 6,
   parameter int  REFRESH_DIV = 50000,
   localparam int COL_W       = idx_width(COLS),
   localparam int ROW_W       = idx_width(ROWS),
   localparam int K_W         = idx_width(DIGITS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ROW_W-1:0]           view_row,
   input  logic [COL_W-1:0]           view_col,
   input  logic                       refresh_req,
   output logic                       rd_en,
   output logic [ROW_W+COL_W-1:0]     rd_addr,
   input  logic [CELL_W-1:0]          rd_data,
   output logic [CELL_W*DIGITS-1:0]   cells,
   output logic                       busy,
   output logic                       frame_done
);

   scan_state_t state_reg, state_next;

   logic [ROW_W-1:0]          row_f_reg;
   logic [COL_W-1:0]          col_ptr_reg;
   logic [K_W-1:0]            k_reg;
   logic                      pending_reg;
   logic                      rd_valid_reg;
   logic [K_W-1:0]            rd_idx_reg;
   cell_t                     shadow_reg [DIGITS];
   logic [CELL_W*DIGITS-1:0]  cells_reg;
   logic                      frame_done_reg;

   logic tick;
   logic start_req;
   logic start;
   logic last_read;

   refresh_timer #(
      .DIV  (REFRESH_DIV)
   ) u_refresh_timer (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign start_req = tick | refresh_req;
   assign start     = (state_reg == ST_IDLE) && (start_req || pending_reg);
   assign last_read = (k_reg == K_W'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start) state_next = ST_SCAN;
         ST_SCAN:   if (last_read) state_next = ST_DRAIN;
         ST_DRAIN:  state_next = ST_COMMIT;
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      busy    = 1'b0;
      case (state_reg)
         ST_SCAN: begin
            rd_en   = 1'b1;
            rd_addr = {row_f_reg, col_ptr_reg};
            busy    = 1'b1;
         end
         ST_DRAIN, ST_COMMIT: busy = 1'b1;
         default: ;
      endcase
   end

   // col_ptr_reg holds the frame's latched view_col and then walks the window;
   // its natural overflow gives the silent column wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_f_reg      <= '0;
         col_ptr_reg    <= '0;
         k_reg          <= '0;
         pending_reg    <= 1'b0;
         rd_valid_reg   <= 1'b0;
         rd_idx_reg     <= '0;
         cells_reg      <= '0;
         frame_done_reg <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            shadow_reg[i] <= '0;
         end
      end else begin
         if (start) begin
            row_f_reg   <= view_row;
            col_ptr_reg <= view_col;
            k_reg       <= '0;
         end else if (state_reg == ST_SCAN) begin
            col_ptr_reg <= col_ptr_reg + COL_W'(1);
            k_reg       <= k_reg + K_W'(1);
         end

         // A start taken in IDLE absorbs any simultaneous request.
         if (state_reg != ST_IDLE && start_req) begin
            pending_reg <= 1'b1;
         end else if (start) begin
            pending_reg <= 1'b0;
         end

         rd_valid_reg <= (state_reg == ST_SCAN);
         rd_idx_reg   <= k_reg;
         for (int i = 0; i < DIGITS; i++) begin
            if (rd_valid_reg && rd_idx_reg == K_W'(i)) begin
               shadow_reg[i] <= rd_data;
            end
         end

         frame_done_reg <= (state_reg == ST_COMMIT);
         if (state_reg == ST_COMMIT) begin
            for (int i = 0; i < DIGITS; i++) begin
               cells_reg[CELL_W*i +: CELL_W] <= shadow_reg[i];
            end
         end
      end
   end

   assign cells      = cells_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_grid_view_scanner.sv
// Directed bench for grid_view_scanner: a slow-refresh instance for requested
// frames and a REFRESH_DIV=16 instance for automatic frames.
module tb_grid_view_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  view_row;
   logic [3:0]  view_col;
   logic        refresh_req;
   logic        rd_en;
   logic [6:0]  rd_addr;
   logic [4:0]  rd_data;
   logic [29:0] cells;
   logic        busy;
   logic        frame_done;

   logic        rst_b;
   logic        rd_en_b;
   logic [6:0]  rd_addr_b;
   logic [4:0]  rd_data_b;
   logic [29:0] cells_b;
   logic        busy_b;
   logic        frame_done_b;

   logic [4:0]  mem [128];

   int total = 0;
   int bad   = 0;

   localparam logic [29:0] EXP1 = {5'd16, 5'd8, 5'd3, 5'd2, 5'd1, 5'd0};
   localparam logic [29:0] EXP2 = {5'd11, 5'd10, 5'd9, 5'd7, 5'd6, 5'd5};
   localparam logic [29:0] EXP3 = {5'd25, 5'd24, 5'd23, 5'd22, 5'd21, 5'd20};

   always #5 clk = ~clk;

   grid_view_scanner #(
      .COLS(16), .ROWS(8), .DIGITS(6), .REFRESH_DIV(4096)
   ) dut_a (
      .clk(clk), .rst(rst), .view_row(view_row), .view_col(view_col),
      .refresh_req(refresh_req), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .cells(cells), .busy(busy), .frame_done(frame_done)
   );

   grid_view_scanner #(
      .COLS(16), .ROWS(8), .DIGITS(6), .REFRESH_DIV(16)
   ) dut_b (
      .clk(clk), .rst(rst_b), .view_row(3'd3), .view_col(4'd7),
      .refresh_req(1'b0), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
      .rd_data(rd_data_b), .cells(cells_b), .busy(busy_b), .frame_done(frame_done_b)
   );

   always @(posedge clk) begin
      if (rd_en)   rd_data   <= mem[rd_addr];
      if (rd_en_b) rd_data_b <= mem[rd_addr_b];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Checks one whole frame from its first rd_en; code 1 moves view_col
   // mid-scan, code 2 pulses refresh_req twice mid-scan.
   task automatic do_frame(input int code, input logic [2:0] row, input logic [3:0] col,
                           input logic [29:0] exp, input logic exp_next);
      bit found = 0;
      logic [3:0] c;
      for (int w = 0; w < 20 && !found; w++) begin
         if (rd_en) found = 1;
         else @(negedge clk);
      end
      chk("frame_start", 32'(found), 32'd1);
      for (int k = 0; k < 6; k++) begin
         c = col + 4'(k);
         chk("rd_en_scan", 32'(rd_en), 32'd1);
         chk("rd_addr", 32'(rd_addr), 32'({row, c}));
         $display("read k=%0d addr=%02h", k, rd_addr);
         if (code == 1 && k == 2) view_col = 4'd7;
         if (code == 2) refresh_req = (k == 1 || k == 3);
         @(negedge clk);
      end
      refresh_req = 1'b0;
      chk("drain_rd_en", 32'(rd_en), 32'd0);
      chk("drain_addr", 32'(rd_addr), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("commit_busy", 32'(busy), 32'd1);
      chk("commit_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      chk("done_fd", 32'(frame_done), 32'd1);
      chk("done_cells", 32'(cells), 32'(exp));
      chk("done_busy", 32'(busy), 32'd0);
      $display("frame row=%0d col=%0d cells=%08h", row, col, cells);
      @(negedge clk);
      chk("fd_single", 32'(frame_done), 32'd0);
      chk("next_rd_en", 32'(rd_en), 32'(exp_next));
   endtask

   task automatic pulse_req();
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
   endtask

   initial begin
      int cnt;
      int next_start;
      int starts;
      int dones;
      logic prev_rd;
      logic [29:0] prev_cells;

      for (int i = 0; i < 128; i++) mem[i] = 5'd0;
      mem[7'h30] = 5'd0;  mem[7'h31] = 5'd1;  mem[7'h32] = 5'd2;
      mem[7'h33] = 5'd3;  mem[7'h34] = 5'd8;  mem[7'h35] = 5'd16;
      mem[7'h36] = 5'd30;
      mem[7'h37] = 5'd20; mem[7'h38] = 5'd21; mem[7'h39] = 5'd22;
      mem[7'h3a] = 5'd23; mem[7'h3b] = 5'd24; mem[7'h3c] = 5'd25;
      mem[7'h0d] = 5'd5;  mem[7'h0e] = 5'd6;  mem[7'h0f] = 5'd7;
      mem[7'h00] = 5'd9;  mem[7'h01] = 5'd10; mem[7'h02] = 5'd11;

      rst = 1'b1; rst_b = 1'b1; refresh_req = 1'b0;
      view_row = 3'd3; view_col = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_cells", 32'(cells), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame, then a wrapping window.
      pulse_req();
      do_frame(0, 3'd3, 4'd0, EXP1, 1'b0);
      view_row = 3'd0; view_col = 4'd13;
      pulse_req();
      do_frame(0, 3'd0, 4'd13, EXP2, 1'b0);
      repeat (4) @(negedge clk);
      chk("cells_hold", 32'(cells), 32'(EXP2));

      // View change during scan only affects the next frame.
      view_row = 3'd3; view_col = 4'd0;
      pulse_req();
      do_frame(1, 3'd3, 4'd0, EXP1, 1'b0);
      pulse_req();
      do_frame(0, 3'd3, 4'd7, EXP3, 1'b0);

      // Two requests during one scan give exactly one extra frame.
      view_col = 4'd0;
      pulse_req();
      do_frame(2, 3'd3, 4'd0, EXP1, 1'b1);
      do_frame(0, 3'd3, 4'd0, EXP1, 1'b0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (rd_en) cnt++;
         @(negedge clk);
      end
      chk("no_third_frame", 32'(cnt), 32'd0);

      // Reset on the third scan cycle aborts the frame.
      view_col = 4'd7;
      pulse_req();
      chk("abort_scan0", 32'(rd_en), 32'd1);
      repeat (2) @(negedge clk);
      chk("abort_scan2", 32'(rd_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_cells", 32'(cells), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd_en", 32'(rd_en), 32'd0);
      chk("abort_fd", 32'(frame_done), 32'd0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (frame_done || rd_en) cnt++;
         @(negedge clk);
      end
      chk("abort_quiet", 32'(cnt), 32'd0);

      // Automatic frames every 16 cycles on the fast instance.
      rst_b = 1'b0;
      next_start = 16; starts = 0; dones = 0;
      prev_rd = 1'b0; prev_cells = cells_b;
      for (int i = 1; i <= 92; i++) begin
         @(negedge clk);
         if (rd_en_b && !prev_rd) begin
            chk("auto_start", 32'(i), 32'(next_start));
            $display("auto frame start at cycle %0d", i);
            next_start += 16;
            starts++;
         end
         if (frame_done_b) dones++;
         else chk("auto_cells_hold", 32'(cells_b), 32'(prev_cells));
         prev_rd = rd_en_b;
         prev_cells = cells_b;
      end
      chk("auto_starts", 32'(starts), 32'd5);
      chk("auto_dones", 32'(dones), 32'd5);
      chk("auto_cells", 32'(cells_b), 32'(EXP3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/grid_view_scanner.md
GRID_VIEW_SCANNER -- requirements
Module: grid_view_scanner

Interface
REQ-001 SHALL have parameter COLS, 16, grid columns (power of two).
REQ-002 SHALL have parameter ROWS, 8, grid rows (power of two).
REQ-003 SHALL have parameter DIGITS, 6, number of displayed cells (one per 7-segment digit).
REQ-004 SHALL have parameter REFRESH_DIV, 50000, clocks between automatic frame starts; legal range is 16 or more.
REQ-005 SHALL have the port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have the port rst, input, 1, a synchronous active-high reset.
REQ-007 SHALL have the port view_row, input, log2(ROWS), the grid row to display.
REQ-008 SHALL have the port view_col, input, log2(COLS), the grid column shown on digit 0.
REQ-009 SHALL have the port refresh_req, input, 1, a one-cycle request for an immediate frame.
REQ-010 SHALL have the port rd_en, output, 1, the grid RAM read strobe.
REQ-011 SHALL have the port rd_addr, output, log2(ROWS*COLS), the grid RAM address {row, col}.
REQ-012 SHALL have the port rd_data, input, 5, the cell code, valid exactly one cycle after rd_en.
REQ-013 SHALL have the port cells, output, 5*DIGITS, the cell codes, with digit k at bits [5k+4:5k]; each slice feeds one downstream blockDisp.
REQ-014 SHALL have the port busy, output, 1, high while a frame scan is in progress.
REQ-015 SHALL have the port frame_done, output, 1, a one-cycle pulse when cells updates.

Function
REQ-016 SHALL run a free refresh counter 0..REFRESH_DIV-1 that wraps and raises an internal start request at the terminal count.
REQ-017 SHALL OR the refresh_req input with the counter start request; a request arriving while busy SHALL set a pending flag (depth 1) that is serviced on the cycle after frame_done.
REQ-018 SHALL implement the FSM IDLE -> SCAN -> DRAIN -> COMMIT -> IDLE.
REQ-019 SHALL, in IDLE, take a start request by latching view_row/view_col into frame registers and entering SCAN on the next cycle; later changes to the view inputs SHALL NOT affect the frame in progress.
REQ-020 SHALL, in SCAN, assert rd_en for exactly DIGITS consecutive cycles with k=0..DIGITS-1 and rd_addr = {row_f, (col_f+k) mod COLS}, the column wrapping silently.
REQ-021 SHALL capture rd_data into shadow[k] on the cycle after read k is issued.
REQ-022 SHALL spend one cycle in DRAIN to capture the last read, with rd_en low.
REQ-023 SHALL, in COMMIT, copy all shadow registers into cells at once and pulse frame_done for one cycle, so that cells never shows a partially updated frame.
REQ-024 SHALL give a latency of DIGITS+2 cycles from the first SCAN cycle to the cells update, which is 8 cycles at the default parameters.
REQ-025 SHALL drive busy high in SCAN, DRAIN and COMMIT, and low in IDLE.
REQ-026 SHALL hold rd_addr at 0 whenever rd_en is low.
REQ-027 SHALL hold cells stable between COMMIT cycles.

Reset
REQ-028 SHALL, on rst high at a clock edge, drive cells to all zeros (empty/blank), busy, frame_done and rd_en to 0, and rd_addr to 0.
REQ-029 SHALL, on the same reset, clear the FSM to IDLE and clear the refresh counter, the pending flag, and the shadow and frame registers.
REQ-030 SHALL abort a scan that is interrupted by reset, leaving no commit and no frame_done.
REQ-031 SHALL allow the first automatic frame to start REFRESH_DIV cycles after rst is released.

Structure
REQ-032 SHALL take the 5-bit cell-code width and the grid dimension constants from the shared antfarm package, which is also used by the grid RAM and the display decoder.
REQ-033 SHALL implement the refresh counter as the sub-module refresh_timer, with parameter DIV and a tick output; the scanner FSM, shadow registers and commit stay in grid_view_scanner.

Verification
REQ-034 SHALL cover: RAM row 3 cols 0..5 preloaded with 0,1,2,3,8,16; view_row=3, view_col=0; pulse refresh_req -> rd_addr 0x30..0x35 on 6 cycles, then cells = {16,8,3,2,1,0} (digit 5..0) and a single frame_done 8 cycles after the first rd_en.
REQ-035 SHALL cover: view_col=13, view_row=0 -> rd_addr sequence 13,14,15,0,1,2.
REQ-036 SHALL cover: view_col changed from 0 to 7 during SCAN -> the current frame still reads cols 0..5, and the next frame reads cols 7..12.
REQ-037 SHALL cover: refresh_req pulsed twice during one scan -> exactly one extra frame, starting the cycle after frame_done.
REQ-038 SHALL cover: rst asserted on the 3rd SCAN cycle -> next cycle cells=0, busy=0, rd_en=0, and no frame_done.
REQ-039 SHALL cover: REFRESH_DIV=16, no refresh_req -> automatic frames start every 16 cycles, and cells is unchanged except in COMMIT cycles.
